// File: rtl/scene_compositor.sv
// Pong-display pixel compositor: NUM_OBJ prioritised rectangles with per-frame
// shadowed bounds, blink gating, a 2-stage pixel pipeline and collision reporting.
module scene_compositor #(
   parameter int NUM_OBJ      = 4,
   parameter int COORD_W      = 11,
   parameter int POS_W        = 10,
   parameter int COLOR_W      = 3,
   parameter int BG_COLOR     = 0,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         pixel_tick,
   input  logic                         frame_tick,
   input  logic                         active,
   input  logic [POS_W-1:0]             hpos,
   input  logic [POS_W-1:0]             vpos,
   input  logic [NUM_OBJ*COORD_W-1:0]   obj_start_w,
   input  logic [NUM_OBJ*COORD_W-1:0]   obj_end_w,
   input  logic [NUM_OBJ*COORD_W-1:0]   obj_start_h,
   input  logic [NUM_OBJ*COORD_W-1:0]   obj_end_h,
   input  logic [NUM_OBJ*COLOR_W-1:0]   obj_color,
   input  logic [NUM_OBJ-1:0]           obj_enable,
   input  logic [NUM_OBJ-1:0]           obj_blink,
   output logic [COLOR_W-1:0]           pixel,
   output logic                         pixel_valid,
   output logic [NUM_OBJ-1:0]           hit_mask,
   output logic [NUM_OBJ-1:0]           collision_mask,
   output logic                         blink_phase
);

   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

   logic [NUM_OBJ*COORD_W-1:0] sw_sh, ew_sh, sh_sh, eh_sh;
   logic [NUM_OBJ*COLOR_W-1:0] col_sh;
   logic [NUM_OBJ-1:0]         en_sh, bl_sh;
   logic [CNT_W-1:0]           blink_cnt;
   logic [NUM_OBJ-1:0]         hit1, coll_acc;
   logic                       act1;

   logic [NUM_OBJ-1:0]         visible, hit_next, coll_new;
   logic [COLOR_W-1:0]         pix_next;
   logic                       multi_hit;

   // Bounds are signed; the unsigned scan position is zero-extended one bit wider
   // so negative bounds clip instead of wrapping.
   function automatic logic in_span(input logic [COORD_W-1:0] lo,
                                    input logic [COORD_W-1:0] hi,
                                    input logic [POS_W-1:0]   p);
      logic signed [COORD_W:0] l, h, q;
      l = {lo[COORD_W-1], lo};
      h = {hi[COORD_W-1], hi};
      q = {{(COORD_W+1-POS_W){1'b0}}, p};
      return (l <= q) && (q <= h);
   endfunction

   always_comb begin
      visible  = en_sh & ~(bl_sh & {NUM_OBJ{blink_phase}});
      hit_next = '0;
      for (int unsigned i = 0; i < NUM_OBJ; i++)
         hit_next[i] = visible[i]
                     & in_span(sw_sh[i*COORD_W +: COORD_W], ew_sh[i*COORD_W +: COORD_W], hpos)
                     & in_span(sh_sh[i*COORD_W +: COORD_W], eh_sh[i*COORD_W +: COORD_W], vpos);
   end

   always_comb begin
      pix_next = COLOR_W'(BG_COLOR);
      for (int unsigned k = 0; k < NUM_OBJ; k++)
         if (hit1[NUM_OBJ-1-k])
            pix_next = col_sh[(NUM_OBJ-1-k)*COLOR_W +: COLOR_W];
      multi_hit = |(hit1 & (hit1 - NUM_OBJ'(1)));
      coll_new  = (pixel_tick && act1 && multi_hit) ? hit1 : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_sh          <= '0;
         ew_sh          <= '0;
         sh_sh          <= '0;
         eh_sh          <= '0;
         col_sh         <= '0;
         en_sh          <= '0;
         bl_sh          <= '0;
         blink_cnt      <= '0;
         blink_phase    <= 1'b0;
         coll_acc       <= '0;
         collision_mask <= '0;
         hit1           <= '0;
         act1           <= 1'b0;
         pixel          <= '0;
         pixel_valid    <= 1'b0;
         hit_mask       <= '0;
      end else begin
         if (frame_tick) begin
            sw_sh  <= obj_start_w;
            ew_sh  <= obj_end_w;
            sh_sh  <= obj_start_h;
            eh_sh  <= obj_end_h;
            col_sh <= obj_color;
            en_sh  <= obj_enable;
            bl_sh  <= obj_blink;
            if (blink_cnt == CNT_LAST) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + CNT_W'(1);
            end
            // A collision resolved in the same cycle still belongs to the closing frame.
            collision_mask <= coll_acc | coll_new;
            coll_acc       <= '0;
         end else begin
            coll_acc <= coll_acc | coll_new;
         end

         if (pixel_tick) begin
            hit1        <= hit_next;
            act1        <= active;
            pixel       <= act1 ? pix_next : '0;
            pixel_valid <= act1;
            hit_mask    <= act1 ? hit1 : '0;
         end
      end
   end

endmodule

// File: tb/tb_scene_compositor.sv
// Bench for scene_compositor: scoreboard of expected pixels (model or table),
// popped after each pixel_tick, plus reset, blink, tear-free and hold sequences.
module tb_scene_compositor;

   localparam int N  = 4;
   localparam int CW = 11;
   localparam int PW = 10;
   localparam int KW = 3;
   localparam int BF = 2;

   logic clk = 1'b0;
   logic rst_n, pixel_tick, frame_tick, active;
   logic [PW-1:0]   hpos, vpos;
   logic [N*CW-1:0] obj_start_w, obj_end_w, obj_start_h, obj_end_h;
   logic [N*KW-1:0] obj_color;
   logic [N-1:0]    obj_enable, obj_blink;
   logic [KW-1:0]   pixel;
   logic            pixel_valid, blink_phase;
   logic [N-1:0]    hit_mask, collision_mask;

   int            o_sw[N], o_ew[N], o_sh[N], o_eh[N];
   logic [KW-1:0] o_col[N];
   logic [N-1:0]  o_en, o_bl;

   int            m_sw[N], m_ew[N], m_sh[N], m_eh[N];
   logic [KW-1:0] m_col[N];
   logic [N-1:0]  m_en, m_bl, acc;
   logic          m_phase;
   int            m_cnt, nticks, lit;
   int            checks = 0, passes = 0;

   typedef struct {
      logic [KW-1:0] pix;
      logic          valid;
      logic [N-1:0]  hit;
   } exp_t;

   typedef struct {
      int   h;
      int   v;
      logic act;
      exp_t e;
   } vec_t;

   exp_t sb[$];
   exp_t last;
   exp_t none;

   scene_compositor #(
      .NUM_OBJ(N), .COORD_W(CW), .POS_W(PW), .COLOR_W(KW),
      .BG_COLOR(0), .BLINK_FRAMES(BF)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pixel_tick(pixel_tick), .frame_tick(frame_tick),
      .active(active), .hpos(hpos), .vpos(vpos),
      .obj_start_w(obj_start_w), .obj_end_w(obj_end_w),
      .obj_start_h(obj_start_h), .obj_end_h(obj_end_h),
      .obj_color(obj_color), .obj_enable(obj_enable), .obj_blink(obj_blink),
      .pixel(pixel), .pixel_valid(pixel_valid), .hit_mask(hit_mask),
      .collision_mask(collision_mask), .blink_phase(blink_phase)
   );

   always #10 clk = ~clk;

   always_comb begin
      obj_start_w = '0;
      obj_end_w   = '0;
      obj_start_h = '0;
      obj_end_h   = '0;
      obj_color   = '0;
      for (int i = 0; i < N; i++) begin
         obj_start_w[i*CW +: CW] = CW'(o_sw[i]);
         obj_end_w[i*CW +: CW]   = CW'(o_ew[i]);
         obj_start_h[i*CW +: CW] = CW'(o_sh[i]);
         obj_end_h[i*CW +: CW]   = CW'(o_eh[i]);
         obj_color[i*KW +: KW]   = o_col[i];
      end
      obj_enable = o_en;
      obj_blink  = o_bl;
   end

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   function automatic exp_t model(input int h, input int v, input logic act);
      exp_t e;
      e.hit = '0;
      e.pix = '0;
      e.valid = act;
      for (int i = 0; i < N; i++)
         if (m_en[i] && !(m_bl[i] && m_phase) &&
             h >= m_sw[i] && h <= m_ew[i] && v >= m_sh[i] && v <= m_eh[i])
            e.hit[i] = 1'b1;
      if (!act) e.hit = '0;
      else
         for (int i = N-1; i >= 0; i--)
            if (e.hit[i]) e.pix = m_col[i];
      return e;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_sw[i] = 0; m_ew[i] = 0; m_sh[i] = 0; m_eh[i] = 0; m_col[i] = '0;
      end
      m_en = '0; m_bl = '0; m_phase = 1'b0; m_cnt = 0; nticks = 0; acc = '0;
      sb.delete();
      sb.push_back(none);
      last = none;
   endtask

   task automatic set_obj(input int i, input int sw, input int ew, input int sh, input int eh,
                          input logic [KW-1:0] col, input logic en, input logic bl);
      o_sw[i] = sw; o_ew[i] = ew; o_sh[i] = sh; o_eh[i] = eh;
      o_col[i] = col; o_en[i] = en; o_bl[i] = bl;
   endtask

   // One pixel_tick clock followed by one idle clock; tab_e overrides the model.
   task automatic tick(input int h, input int v, input logic act, input logic ft,
                       input logic use_tab, input exp_t tab_e);
      exp_t e, g;
      @(negedge clk);
      hpos = PW'(h); vpos = PW'(v); active = act; pixel_tick = 1'b1; frame_tick = ft;
      e = use_tab ? tab_e : model(h, v, act);
      sb.push_back(e);
      if (ft) begin
         for (int i = 0; i < N; i++) begin
            m_sw[i] = o_sw[i]; m_ew[i] = o_ew[i]; m_sh[i] = o_sh[i]; m_eh[i] = o_eh[i];
            m_col[i] = o_col[i];
         end
         m_en = o_en; m_bl = o_bl; nticks++;
         if (m_cnt == BF-1) begin m_cnt = 0; m_phase = ~m_phase; end
         else m_cnt++;
      end
      @(posedge clk); #1;
      g = sb.pop_front();
      chk("pixel", pixel, g.pix);
      chk("pixel_valid", pixel_valid, g.valid);
      chk("hit_mask", hit_mask, g.hit);
      if (pixel_valid && pixel != 0) lit++;
      if (g.valid && $countones(g.hit) >= 2) acc |= g.hit;
      if (ft) begin
         chk("collision_mask", collision_mask, acc);
         chk("blink_phase", blink_phase, m_phase);
         acc = '0;
      end
      last = g;
      @(negedge clk);
      pixel_tick = 1'b0; frame_tick = 1'b0;
   endtask

   task automatic px(input int h, input int v, input logic act, input logic ft);
      tick(h, v, act, ft, 1'b0, none);
   endtask

   task automatic hold(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         hpos = PW'($urandom); vpos = PW'($urandom); active = 1'($urandom);
         pixel_tick = 1'b0; frame_tick = 1'b0;
         @(posedge clk); #1;
         chk("hold_pixel", pixel, last.pix);
         chk("hold_valid", pixel_valid, last.valid);
         chk("hold_hit", hit_mask, last.hit);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async_rst_out", {pixel, pixel_valid, hit_mask, collision_mask, blink_phase}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   vec_t tab[11];

   initial begin
      none.pix = '0; none.valid = 1'b0; none.hit = '0;
      tab[0]  = '{100, 100, 1'b1, '{3'b100, 1'b1, 4'b0011}};
      tab[1]  = '{110, 110, 1'b1, '{3'b100, 1'b1, 4'b0011}};
      tab[2]  = '{111, 110, 1'b1, '{3'b000, 1'b1, 4'b0000}};
      tab[3]  = '{ 99, 105, 1'b1, '{3'b000, 1'b1, 4'b0000}};
      tab[4]  = '{  0,   0, 1'b1, '{3'b001, 1'b1, 4'b0100}};
      tab[5]  = '{  2,   9, 1'b1, '{3'b001, 1'b1, 4'b0100}};
      tab[6]  = '{  3,   5, 1'b1, '{3'b000, 1'b1, 4'b0000}};
      tab[7]  = '{  7,   5, 1'b1, '{3'b000, 1'b1, 4'b0000}};
      tab[8]  = '{  8,   5, 1'b1, '{3'b000, 1'b1, 4'b0000}};
      tab[9]  = '{105, 105, 1'b0, '{3'b000, 1'b0, 4'b0000}};
      tab[10] = '{  0,  10, 1'b1, '{3'b000, 1'b1, 4'b0000}};

      rst_n = 1'b0; pixel_tick = 1'b0; frame_tick = 1'b0; active = 1'b0;
      hpos = '0; vpos = '0; o_en = '0; o_bl = '0;
      for (int i = 0; i < N; i++) set_obj(i, 0, 0, 0, 0, '0, 1'b0, 1'b0);

      // T1: reset with random activity
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         pixel_tick = 1'($urandom); frame_tick = 1'($urandom); active = 1'($urandom);
         hpos = PW'($urandom); vpos = PW'($urandom);
         for (int i = 0; i < N; i++)
            set_obj(i, $urandom_range(0, 600), $urandom_range(0, 600), $urandom_range(0, 400),
                    $urandom_range(0, 400), KW'($urandom), 1'($urandom), 1'($urandom));
         @(posedge clk); #1;
         chk("reset_out", {pixel, pixel_valid, hit_mask, collision_mask, blink_phase}, 0);
      end
      @(negedge clk);
      rst_n = 1'b1; pixel_tick = 1'b0; frame_tick = 1'b0;
      model_reset();

      // T2: single object, nothing drawn until the first frame_tick
      for (int i = 0; i < N; i++) set_obj(i, 0, 0, 0, 0, '0, 1'b0, 1'b0);
      set_obj(0, 10, 14, 20, 24, 3'b111, 1'b1, 1'b0);
      px(12, 22, 1'b1, 1'b0);
      px(12, 22, 1'b1, 1'b0);
      px(0, 0, 1'b0, 1'b1);
      lit = 0;
      for (int v = 15; v < 30; v++)
         for (int h = 0; h < 40; h++)
            px(h, v, 1'b1, 1'b0);
      px(639, 479, 1'b1, 1'b0);
      px(0, 0, 1'b0, 1'b0);
      chk("t2_lit_count", lit, 25);

      // T3/T6: priority, overlap, negative and empty bounds, inactive hit
      set_obj(0, 100, 110, 100, 110, 3'b100, 1'b1, 1'b0);
      set_obj(1, 100, 110, 100, 110, 3'b010, 1'b1, 1'b0);
      set_obj(2, -5, 2, 0, 9, 3'b001, 1'b1, 1'b0);
      set_obj(3, 8, 7, 0, 9, 3'b101, 1'b1, 1'b0);
      px(0, 0, 1'b0, 1'b1);
      for (int t = 0; t < 11; t++) begin
         tick(tab[t].h, tab[t].v, tab[t].act, 1'b0, 1'b1, tab[t].e);
         if (t == 1) hold(3);
      end
      px(0, 0, 1'b0, 1'b1);
      chk("t3_collision", collision_mask, 4'b0011);
      px(105, 105, 1'b0, 1'b0);
      px(105, 105, 1'b0, 1'b0);
      px(0, 0, 1'b0, 1'b1);
      chk("t6_inactive_no_collision", collision_mask, 4'b0000);

      // T4: mid-frame move stays invisible until the next frame_tick
      for (int i = 1; i < N; i++) o_en[i] = 1'b0;
      set_obj(0, 50, 54, 200, 204, 3'b110, 1'b1, 1'b0);
      px(0, 0, 1'b0, 1'b1);
      px(52, 202, 1'b1, 1'b0);
      o_sw[0] = 300; o_ew[0] = 304;
      px(52, 202, 1'b1, 1'b0);
      px(302, 202, 1'b1, 1'b0);
      px(52, 202, 1'b1, 1'b1);
      px(52, 202, 1'b1, 1'b0);
      px(302, 202, 1'b1, 1'b0);
      px(303, 204, 1'b1, 1'b0);

      // Mid-frame reset with a lit pixel in flight
      do_reset();
      chk("post_rst_collision", collision_mask, 0);
      px(302, 202, 1'b1, 1'b0);
      px(302, 202, 1'b1, 1'b0);

      // T5: blink with BLINK_FRAMES=2
      for (int i = 0; i < N; i++) set_obj(i, 0, 0, 0, 0, '0, 1'b0, 1'b0);
      set_obj(0, 0, 3, 0, 3, 3'b011, 1'b1, 1'b1);
      set_obj(1, 10, 13, 0, 3, 3'b101, 1'b1, 1'b0);
      for (int k = 1; k <= 6; k++) begin
         px(0, 0, 1'b0, 1'b1);
         chk("t5_phase_seq", blink_phase, (k / 2) % 2);
         px(1, 1, 1'b1, 1'b0);
         px(11, 1, 1'b1, 1'b0);
         px(0, 0, 1'b0, 1'b0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
